// File: rtl/mss_serial_read_unit.sv
// mss_serial_read_unit
//   Main-store serial read unit. Latches a store line address on request,
//   captures that line's parallel word on the next beat-start strobe (w_XTB),
//   then shifts it out LSB-first, one digit per w_DPG, followed by a flyback
//   gap so the beat lines up with the accumulator's digit/flyback timing.
//
// Optional feature (compile-time macro MSS_READ_NEGATE_EN):
//   Adds input w_NEGATE, sampled with w_READ_REQ in IDLE. When set, the
//   captured word is two's-complement negated before it is serialised.
//
// Ports
//   w_DPG          in   digit pulse clock, all logic on posedge
//   w_RESET        in   synchronous active-high reset
//   w_XTB          in   beat-start strobe (one DPG cycle wide)
//   w_READ_REQ     in   read request level, sampled only in IDLE
//   b_MS_ADDR      in   line address, sampled with w_READ_REQ
//   b_MS_LINE_DATA in   parallel word of the line on b_MS_LINE_ADDR
//   w_NEGATE       in   (MSS_READ_NEGATE_EN only) negate captured word
//   b_MS_LINE_ADDR out  registered line select to the store tube
//   w_A_DATA_IN    out  serial data to the accumulator, LSB first
//   w_DATA_VALID   out  high while w_A_DATA_IN carries a data digit
//   w_BUSY         out  high in any state other than IDLE
//   w_READ_ACK     out  one-cycle pulse at the end of flyback
module mss_serial_read_unit #(
  parameter int INSTR_BITS   = 20,
  parameter int ADDR_BITS    = 5,
  parameter int FLYBACK_TIME = 4
) (
  input  logic                  w_DPG,
  input  logic                  w_RESET,
  input  logic                  w_XTB,
  input  logic                  w_READ_REQ,
  input  logic [ADDR_BITS-1:0]  b_MS_ADDR,
  input  logic [INSTR_BITS-1:0] b_MS_LINE_DATA,
`ifdef MSS_READ_NEGATE_EN
  input  logic                  w_NEGATE,
`endif
  output logic [ADDR_BITS-1:0]  b_MS_LINE_ADDR,
  output logic                  w_A_DATA_IN,
  output logic                  w_DATA_VALID,
  output logic                  w_BUSY,
  output logic                  w_READ_ACK
);

  localparam int CW = $clog2(INSTR_BITS + FLYBACK_TIME) + 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(INSTR_BITS);
  localparam logic [CW-1:0] FLY_LAST   = CW'(FLYBACK_TIME);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_SHIFT   = 2'd2,
    S_FLYBACK = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [INSTR_BITS-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic                  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic [INSTR_BITS-1:0] cap_word;

`ifdef MSS_READ_NEGATE_EN
  logic neg_q, neg_d;
`endif

  // Word as it will be serialised if captured this cycle.
  always_comb begin
    cap_word = b_MS_LINE_DATA;
`ifdef MSS_READ_NEGATE_EN
    if (neg_q) cap_word = ~b_MS_LINE_DATA + INSTR_BITS'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = busy_q;
    ack_d   = 1'b0;
`ifdef MSS_READ_NEGATE_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_READ_REQ) begin
          addr_d  = b_MS_ADDR;
          busy_d  = 1'b1;
          state_d = S_ARMED;
`ifdef MSS_READ_NEGATE_EN
          neg_d   = w_NEGATE;
`endif
        end
      end
      S_ARMED: begin
        // Digit 0 goes out directly; the rest is held pre-shifted.
        if (w_XTB) begin
          sreg_d  = cap_word >> 1;
          dout_d  = cap_word[0];
          valid_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q < LAST_DIGIT) begin
          dout_d  = sreg_q[0];
          valid_d = 1'b1;
          sreg_d  = sreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end else if (FLYBACK_TIME == 0) begin
          // No flyback gap: the beat completes on the SHIFT exit edge.
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          fcnt_d  = CW'(1);
          state_d = S_FLYBACK;
        end
      end
      S_FLYBACK: begin
        if (fcnt_q == FLY_LAST) begin
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          fcnt_d  = fcnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_DPG) begin
    if (w_RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef MSS_READ_NEGATE_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
`ifdef MSS_READ_NEGATE_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign b_MS_LINE_ADDR = addr_q;
  assign w_A_DATA_IN    = dout_q;
  assign w_DATA_VALID   = valid_q;
  assign w_BUSY         = busy_q;
  assign w_READ_ACK     = ack_q;

endmodule

// File: tb/tb_mss_serial_read_unit.sv
// Directed bench for mss_serial_read_unit (INSTR_BITS=20, ADDR_BITS=5,
// FLYBACK_TIME=4). A small store array models the tube output combinationally
// from b_MS_LINE_ADDR. Inputs change 1 time unit after posedge; outputs are
// sampled at the same point.
module tb_mss_serial_read_unit;
  localparam int IB = 20;
  localparam int AB = 5;
  localparam int FT = 4;

  logic          clk = 1'b0;
  logic          rst, xtb, req;
  logic [AB-1:0] addr, line_addr;
  logic [IB-1:0] line_data;
  logic          dout, valid, busy, ack;
`ifdef MSS_READ_NEGATE_EN
  logic          neg;
`endif

  logic [IB-1:0] mem [0:(1<<AB)-1];
  assign line_data = mem[line_addr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cyc  = 0;
  int a1, n_ack;

  always #5 clk = ~clk;

  mss_serial_read_unit #(.INSTR_BITS(IB), .ADDR_BITS(AB), .FLYBACK_TIME(FT)) dut (
    .w_DPG         (clk),
    .w_RESET       (rst),
    .w_XTB         (xtb),
    .w_READ_REQ    (req),
    .b_MS_ADDR     (addr),
    .b_MS_LINE_DATA(line_data),
`ifdef MSS_READ_NEGATE_EN
    .w_NEGATE      (neg),
`endif
    .b_MS_LINE_ADDR(line_addr),
    .w_A_DATA_IN   (dout),
    .w_DATA_VALID  (valid),
    .w_BUSY        (busy),
    .w_READ_ACK    (ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called right after the capturing XTB edge. Collects the 20 digits, then
  // the flyback gap, then expects ACK on the 24th edge. xtb_at pulses w_XTB
  // on the edge ending iteration xtb_at (-1 for none).
  task automatic beat(input string tag, input logic [IB-1:0] exp, input int xtb_at);
    logic [IB-1:0] got;
    int vc, bad;
    got = '0;
    vc  = 0;
    bad = 0;
    for (int i = 0; i < IB + FT; i++) begin
      if (i < IB) begin
        got[i] = dout;
        if (valid) vc++;
        if (ack) bad++;
      end else if (valid || dout || ack) begin
        bad++;
      end
      if (i == xtb_at) xtb = 1'b1;
      tick();
      xtb = 1'b0;
    end
    chk({tag, " word"}, 32'(got), 32'(exp));
    chk({tag, " valid_cnt"}, 32'(vc), 32'(IB));
    chk({tag, " gap"}, 32'(bad), 32'd0);
    chk({tag, " ack"}, 32'(ack), 32'd1);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    ack_cyc = cyc;
    tick();
    chk({tag, " ack_drop"}, 32'(ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1<<AB); i++) mem[i] = '0;
    rst = 1'b1; xtb = 1'b0; req = 1'b0; addr = '0;
`ifdef MSS_READ_NEGATE_EN
    neg = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst addr",  32'(line_addr), 32'd0);
    chk("rst data",  32'(dout),      32'd0);
    chk("rst valid", 32'(valid),     32'd0);
    chk("rst busy",  32'(busy),      32'd0);
    chk("rst ack",   32'(ack),       32'd0);

    // Reset in the middle of SHIFT aborts, no ACK afterwards.
    mem[12] = 20'h12345;
    req = 1'b1; addr = 5'd12; tick(); req = 1'b0;
    xtb = 1'b1; tick(); xtb = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort pre valid", 32'(valid), 32'd1);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("abort addr",  32'(line_addr), 32'd0);
    chk("abort data",  32'(dout),      32'd0);
    chk("abort valid", 32'(valid),     32'd0);
    chk("abort busy",  32'(busy),      32'd0);
    n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      if (ack || valid) n_ack++;
      tick();
    end
    chk("abort no_ack", 32'(n_ack), 32'd0);

    // Basic read: XTB three cycles after the request edge.
    mem[7] = 20'hA5C3F;
    req = 1'b1; addr = 5'd7; tick(); req = 1'b0; addr = 5'd0;
    chk("basic busy", 32'(busy), 32'd1);
    chk("basic addr", 32'(line_addr), 32'd7);
    tick(); tick();
    chk("basic armed valid", 32'(valid), 32'd0);
    xtb = 1'b1; tick(); xtb = 1'b0;
    beat("basic", 20'hA5C3F, -1);

    // Stray XTB in IDLE and on the request edge, then one at digit 10.
    xtb = 1'b1; tick(); xtb = 1'b0;
    chk("stray idle busy", 32'(busy), 32'd0);
    mem[2] = 20'h00001;
    req = 1'b1; addr = 5'd2; xtb = 1'b1; tick(); req = 1'b0; xtb = 1'b0;
    chk("stray armed busy", 32'(busy), 32'd1);
    tick();
    chk("stray entry xtb", 32'(valid), 32'd0);
    xtb = 1'b1; tick(); xtb = 1'b0;
    beat("stray", 20'h00001, 9);

    // Store data changes right after capture; highest address.
    mem[31] = 20'hFFFFF;
    req = 1'b1; addr = 5'd31; tick(); req = 1'b0;
    chk("late addr", 32'(line_addr), 32'd31);
    xtb = 1'b1; tick(); xtb = 1'b0;
    mem[31] = 20'h00000;
    beat("late", 20'hFFFFF, -1);

    // Back-to-back with request held: the XTB on the ACK edge lands while
    // still in FLYBACK, so the second word is captured on the following XTB.
    mem[3] = 20'hABCDE;
    mem[4] = 20'h13579;
    req = 1'b1; addr = 5'd3; tick(); addr = 5'd4;
    xtb = 1'b1; tick(); xtb = 1'b0;
    beat("b2b0", 20'hABCDE, 23);
    a1 = ack_cyc;
    chk("b2b rearm addr", 32'(line_addr), 32'd4);
    chk("b2b rearm busy", 32'(busy), 32'd1);
    for (int i = 0; i < 22; i++) tick();
    chk("b2b no restart", 32'(valid), 32'd0);
    xtb = 1'b1; tick(); xtb = 1'b0; req = 1'b0;
    beat("b2b1", 20'h13579, -1);
    chk("b2b ack spacing", 32'(ack_cyc - a1), 32'd48);

`ifdef MSS_READ_NEGATE_EN
    mem[9] = 20'h00003;
    req = 1'b1; addr = 5'd9; neg = 1'b1; tick(); req = 1'b0; neg = 1'b0;
    xtb = 1'b1; tick(); xtb = 1'b0;
    beat("neg1", 20'hFFFFD, -1);
    req = 1'b1; addr = 5'd9; neg = 1'b0; tick(); req = 1'b0;
    xtb = 1'b1; tick(); xtb = 1'b0;
    beat("neg0", 20'h00003, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
